// File: rtl/div32_seq_ctrl_pkg.sv
// Shared encodings and constants for the sequential 32-bit divider controller.
package div32_seq_ctrl_pkg;

    // funct3[1:0] of the RISC-V M-extension divide group
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    // Sequencer states; IDLE must stay at zero so reset lands there
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_NRM_D = 3'd1;
    localparam logic [2:0] S_NRM_N = 3'd2;
    localparam logic [2:0] S_ITER  = 3'd3;
    localparam logic [2:0] S_FIX   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // Architecturally defined results for divide-by-zero and signed overflow
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_QUOT  = 32'h8000_0000;

    // Two's-complement negate when neg is set; 0x80000000 maps to itself
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/div32_seq_ctrl_norm.sv
// 32-bit unsigned normalizer: leading-zero count and the value shifted left by it.
// An all-zero input reports a shift of 31 so callers see a "one-bit" magnitude.
module div32_seq_ctrl_norm (
    input  logic [31:0] in_val,
    output logic [4:0]  left_sh,
    output logic [31:0] norm_out
);

    // Priority scan: the highest set bit wins because it is visited last
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        left_sh = 5'd31;
        for (int i = 0; i < 32; i++) begin
            if (in_val[i]) begin
                left_sh = 5'(31 - i);
            end
        end
        norm_out = in_val << left_sh;
    end

endmodule

// File: rtl/div32_seq_ctrl.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer. One shared normalizer is used first
// for the divisor and then for the dividend; the leading-zero difference sets
// how many restoring steps are needed, skipping quotient bits known to be zero.
module div32_seq_ctrl
    import div32_seq_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            div_zero
);

    logic [2:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic        sn_q, sn_d, sd_q, sd_d;
    logic        dz_q, dz_d, ovf_q, ovf_d;
    logic [31:0] mag_n_q, mag_n_d;
    logic [31:0] mag_d_q, mag_d_d;   // |divisor|, replaced by its normalized form in NRM_D
    logic [4:0]  lz_d_q, lz_d_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dsh_q, dsh_d;
    logic [31:0] result_q, result_d;
    logic        div_zero_q, div_zero_d;

    logic [31:0] norm_in, norm_out;
    logic [4:0]  norm_lz;
    logic        signed_op;
    logic [31:0] fix_q, fix_r;

    div32_seq_ctrl_norm u_norm (
        .in_val   (norm_in),
        .left_sh  (norm_lz),
        .norm_out (norm_out)
    );

    // Next-state, normalizer input select and datapath update for each state
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sn_d       = sn_q;
        sd_d       = sd_q;
        dz_d       = dz_q;
        ovf_d      = ovf_q;
        mag_n_d    = mag_n_q;
        mag_d_d    = mag_d_q;
        lz_d_d     = lz_d_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dsh_d      = dsh_q;
        result_d   = result_q;
        div_zero_d = div_zero_q;
        norm_in    = 32'd0;
        signed_op  = (op == OP_DIV) || (op == OP_REM);
        fix_q      = 32'd0;
        fix_r      = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    sn_d    = signed_op && dividend[31];
                    sd_d    = signed_op && divisor[31];
                    mag_n_d = cond_neg(dividend, signed_op && dividend[31]);
                    mag_d_d = cond_neg(divisor, signed_op && divisor[31]);
                    dz_d    = (divisor == 32'd0);
                    ovf_d   = signed_op && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
                    state_d = S_NRM_D;
                end
            end
            S_NRM_D: begin
                norm_in = mag_d_q;
                mag_d_d = norm_out;
                lz_d_d  = norm_lz;
                state_d = S_NRM_N;
            end
            S_NRM_N: begin
                norm_in = mag_n_q;
                rem_d   = mag_n_q;
                quo_d   = 32'd0;
                // Normalized divisor shifted back by lzN equals |divisor| << (lzD - lzN)
                dsh_d   = mag_d_q >> norm_lz;
                if (dz_q || ovf_q || (lz_d_q < norm_lz)) begin
                    cnt_d   = 6'd0;
                    state_d = S_FIX;
                end else begin
                    cnt_d   = {1'b0, lz_d_q} - {1'b0, norm_lz} + 6'd1;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (rem_q >= dsh_q) begin
                    rem_d = rem_q - dsh_q;
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    quo_d = {quo_q[30:0], 1'b0};
                end
                dsh_d = dsh_q >> 1;
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (dz_q) begin
                    fix_q = DIV0_QUOT;
                    fix_r = cond_neg(mag_n_q, sn_q);
                end else if (ovf_q) begin
                    fix_q = OVF_QUOT;
                    fix_r = 32'd0;
                end else begin
                    fix_q = cond_neg(quo_q, sn_q ^ sd_q);
                    fix_r = cond_neg(rem_q, sn_q);
                end
                result_d   = op_q[1] ? fix_r : fix_q;
                div_zero_d = dz_q;
                state_d    = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset that aborts any operation in flight
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= 2'd0;
            sn_q       <= 1'b0;
            sd_q       <= 1'b0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
            mag_n_q    <= 32'd0;
            mag_d_q    <= 32'd0;
            lz_d_q     <= 5'd0;
            cnt_q      <= 6'd0;
            rem_q      <= 32'd0;
            quo_q      <= 32'd0;
            dsh_q      <= 32'd0;
            result_q   <= 32'd0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            sn_q       <= sn_d;
            sd_q       <= sd_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
            mag_n_q    <= mag_n_d;
            mag_d_q    <= mag_d_d;
            lz_d_q     <= lz_d_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dsh_q      <= dsh_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div32_seq_ctrl.sv
// Self-checking bench for div32_seq_ctrl: directed corner cases, randomized
// operands against an arithmetic reference model, backpressure and abort.
module tb_div32_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] result;
    logic        out_valid;
    logic        out_ready;
    logic        div_zero;

    int n_checks = 0;
    int n_errors = 0;

    div32_seq_ctrl #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ready     (ready),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Leading-zero count with the normalizer's convention for zero
    function automatic int clz(input logic [31:0] v);
        if (v == 32'd0) return 31;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) return 31 - i;
        end
        return 31;
    endfunction

    // RISC-V division semantics plus expected step count
    task automatic model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic dz, output int n);
        logic        sgn, ovf;
        logic [31:0] ma, mb, q, r;
        int          lzd, lzn;
        sgn = !mop[0];
        dz  = (b == 32'd0);
        ovf = sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ma  = (sgn && a[31]) ? -a : a;
        mb  = (sgn && b[31]) ? -b : b;
        lzd = clz(mb);
        lzn = clz(ma);
        n   = (dz || ovf || lzd < lzn) ? 0 : lzd - lzn + 1;
        if (dz) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (ovf) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        res = mop[1] ? r : q;
    endtask

    // Issue one request, then check latency, result and div_zero at first out_valid
    task automatic run_op(input string tag, input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_res;
        logic        exp_dz;
        int          n, waited, lat;
        model(mop, a, b, exp_res, exp_dz, n);
        @(negedge clk);
        waited = 0;
        while (!ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) begin
            check({tag, "_ready_timeout"}, 32'(ready), 32'd1);
            return;
        end
        start    = 1'b1;
        op       = mop;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        op       = 2'($urandom_range(0, 3));
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 60);
        check({tag, "_latency"}, 32'(lat), 32'(4 + n));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_div_zero"}, 32'(div_zero), 32'(exp_dz));
    endtask

    // With out_ready high the transfer happens on the next edge
    task automatic finish_xfer(input string tag);
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(ready), 32'd1);
    endtask

    initial begin
        logic [31:0] hold_res;
        int          stale;
        rst       = 1'b1;
        start     = 1'b0;
        op        = 2'd0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_div_zero", 32'(div_zero), 32'd0);
        rst = 1'b0;

        // Directed corner cases
        run_op("divu_100_7", 2'b01, 32'd100, 32'd7);               finish_xfer("divu_100_7");
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7);               finish_xfer("remu_100_7");
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);           finish_xfer("div_m7_2");
        run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);           finish_xfer("rem_m7_2");
        run_op("divu_5_0", 2'b01, 32'd5, 32'd0);                   finish_xfer("divu_5_0");
        run_op("remu_5_0", 2'b11, 32'd5, 32'd0);                   finish_xfer("remu_5_0");
        run_op("rem_neg_0", 2'b10, 32'h8000_0000, 32'd0);          finish_xfer("rem_neg_0");
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);    finish_xfer("div_ovf");
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);    finish_xfer("rem_ovf");
        run_op("divu_3_10", 2'b01, 32'd3, 32'd10);                 finish_xfer("divu_3_10");
        run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1);         finish_xfer("divu_max_1");
        run_op("div_0_1", 2'b00, 32'd0, 32'd1);                    finish_xfer("div_0_1");
        run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE);           finish_xfer("rem_7_m2");
        run_op("divu_minint", 2'b01, 32'h8000_0000, 32'h8000_0000); finish_xfer("divu_minint");

        // Randomized operands with biased shapes
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b;
            logic [1:0]  mop;
            mop = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            case ($urandom_range(0, 5))
                0: b = b >> $urandom_range(0, 31);
                1: b = 32'($urandom_range(0, 15));
                2: a = a >> $urandom_range(0, 31);
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: b = 32'd0;
                default: ;
            endcase
            run_op("rand", mop, a, b);
            finish_xfer("rand");
        end

        // Backpressure: result held, ready low, start ignored while in DONE
        out_ready = 1'b0;
        run_op("bp_divu", 2'b01, 32'd100, 32'd7);
        hold_res = result;
        for (int i = 0; i < 10; i++) begin
            start    = 1'b1;
            op       = 2'b01;
            dividend = $urandom;
            divisor  = 32'd3;
            @(negedge clk);
            check("bp_result_hold", result, 32'd14);
            check("bp_valid_hold", 32'(out_valid), 32'd1);
            check("bp_ready_low", 32'(ready), 32'd0);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_drop", 32'(out_valid), 32'd0);
        check("bp_ready_back", 32'(ready), 32'd1);
        @(negedge clk);
        check("bp_no_accept", 32'(ready), 32'd1);
        check("bp_result_kept", result, hold_res);

        // Abort during ITER: no output may ever appear for the aborted request
        run_op("pre_abort", 2'b01, 32'd9, 32'd3);
        finish_xfer("pre_abort");
        start    = 1'b1;
        op       = 2'b01;
        dividend = 32'hFFFF_FFFF;
        divisor  = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_busy", 32'(ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_result", result, 32'd0);
        stale = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("abort_no_stale", 32'(stale), 32'd0);

        run_op("post_abort", 2'b00, 32'hFFFF_FF9C, 32'd7);
        finish_xfer("post_abort");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/div32_seq_ctrl.md
Name: div32_seq_ctrl

Overview:
- Multi-cycle sequencer for RISC-V M-extension DIV/DIVU/REM/REMU, sitting beside the MULDIV datapath.
- Owns a single shared instance of the team's 32-bit unsigned normalizer (leading-zero count plus left shift). It time-multiplexes that instance between divisor and dividend.
- Uses the two leading-zero counts to skip quotient bits that are known to be zero, then runs one restoring-division step per cycle.
- Applies RISC-V sign and corner-case rules and returns the result over a valid/ready handshake.

Parameters:
- XLEN, 32, operand width; only 32 is supported because the normalizer is fixed at 32 bits.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request valid
- ready  out  1  high only in IDLE; request accepted on the edge where start && ready
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
- dividend  in  32  rs1, sampled on accept
- divisor  in  32  rs2, sampled on accept
- result  out  32  quotient (op[1]=0) or remainder (op[1]=1), stable while out_valid
- out_valid  out  1  result valid
- out_ready  in  1  consumer accept; the transfer happens on the edge where out_valid && out_ready
- div_zero  out  1  divisor was 0, qualified by out_valid

Behaviour:
- Reset: state=IDLE, ready=1, out_valid=0, result=0, div_zero=0, all internal registers cleared.
  - rst has priority over everything and aborts any operation in flight, in any state, on the next edge; no output is produced for an aborted request.
- States: IDLE -> NRM_D -> NRM_N -> ITER (n cycles, n may be 0) -> FIX -> DONE -> IDLE.
- IDLE, on accept:
  - latch op, sign flags (signed ops only: sN = dividend[31], sD = divisor[31]);
  - latch magnitudes |dividend| and |divisor|; 0x80000000 stays 0x80000000 as unsigned;
  - latch flag dz = (divisor==0);
  - latch flag ovf = signed op && dividend==0x80000000 && divisor==0xFFFFFFFF.
- NRM_D: normalizer input = |divisor|; register lzD = leftSh.
- NRM_N: normalizer input = |dividend|; register lzN = leftSh.
  - If dz, ovf or lzD < lzN: n = 0.
  - Otherwise n = lzD - lzN + 1, range 1..32 (6-bit counter).
  - Register rem = |dividend|, q = 0, dsh = |divisor| << (lzD - lzN).
  - Normalizer input is 0 in all other states.
- ITER, one step per cycle while the counter is non-zero:
  - if rem >= dsh then rem -= dsh and q = {q[30:0],1}; else q = {q[30:0],0};
  - then dsh >>= 1 and decrement the counter;
  - leave to FIX when the counter reaches 0;
  - n==0 bypasses ITER.
- FIX:
  - dz: q = 0xFFFFFFFF, r = original dividend (signed and unsigned).
  - ovf: q = 0x80000000, r = 0.
  - otherwise, signed: q negated if sN^sD; r negated if sN (remainder takes the dividend's sign).
  - Select the result by op[1]; register result and div_zero.
- DONE: out_valid = 1.
  - result and div_zero are held until out_ready; DONE -> IDLE on the transfer edge.
  - ready rises the cycle after the transfer; there is no accept in the same cycle as the transfer.
- Latency: out_valid is first high 4+n cycles after the accept edge.
  - Minimum 4 cycles (dz, ovf, or dividend magnitude < divisor magnitude).
  - Maximum 36 cycles (e.g. 0xFFFFFFFF / 1).
- start while busy is ignored; inputs need not be held after accept.
- Dividend 0: lzN = 31 (normalizer convention). This correctly yields q=0, r=0.

Decomposition:
- Shared package holds:
  - op encodings OP_DIV/OP_DIVU/OP_REM/OP_REMU;
  - state encoding (IDLE, NRM_D, NRM_N, ITER, FIX, DONE);
  - constants DIV0_QUOT = 32'hFFFFFFFF and OVF_QUOT = 32'h80000000.
- Sub-modules:
  - Instantiate the existing 32-bit normalizer exactly once; the shared-instance mux is the core of this block.
  - The iteration step (compare/subtract/shift) may be a small sub-module named div_step32; otherwise it is inline.

Test Plan:
- DIVU 100/7 -> lzD=29, lzN=25, n=5, out_valid 9 cycles after accept, result=14; repeat with REMU -> result=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> result 0xFFFFFFFD; REM -> result 0xFFFFFFFF; latency 4+n with n=2.
- DIVU 5/0 -> result 0xFFFFFFFF, div_zero=1, latency 4; REMU 5/0 -> result 5.
- DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000, latency 4; REM -> result 0, div_zero=0.
- DIVU 3/10 -> n=0, result 0, latency 4; DIVU 0xFFFFFFFF/1 -> result 0xFFFFFFFF, latency 36.
- Backpressure and reset:
  - hold out_ready=0 for 10 cycles in DONE -> result stable, ready=0, new start ignored;
  - assert rst during ITER -> next cycle ready=1, out_valid=0, no stale result appears later.
